differentiator: RTL and testbench
=================================

// Module: differentiator
//
// PURPOSE
//   Streaming first-difference block, the inverse of the accumulator:
//   y[n] = x[n] - x[n-DELAY], computed modulo 2^DATA_WIDTH.
//   It sits downstream of an accumulator or integrator in decimation and comb chains.
//   accumulator -> differentiator (DELAY=1) must return the original sample stream bit-exactly.
//   Output is registered and carries a valid/ready backpressure handshake.
//
// PARAMETERS
//   DATA_WIDTH  32  width of input samples, output samples and the delay line
//   DELAY        1  comb depth M, in accepted samples; must be >= 1 (elaboration check)
//
// PORTS
//   i_CLK       in   1           single clock; all state updates on rising edge
//   i_RESET_N   in   1           reset, synchronous, active-low
//   i_ENABLE    in   1           input sample valid
//   i_DATA_IN   in   DATA_WIDTH  input sample x[n]
//   o_READY     out  1           block can accept a sample this cycle
//   o_VALID     out  1           o_DATA_OUT holds an unconsumed result
//   o_DATA_OUT  out  DATA_WIDTH  difference y[n]
//   o_PRIMED    out  1           current output used a real x[n-DELAY], not zero fill
//   i_READY     in   1           downstream consumes o_DATA_OUT when o_VALID && i_READY
//
// BEHAVIOUR
//   - Reset (i_RESET_N=0 at posedge) clears:
//     - outputs: o_VALID=0, o_DATA_OUT=0, o_PRIMED=0
//     - internal state: all DELAY delay-line entries=0, prime count=0
//   - Reset overrides any concurrent accept or consume.
//   - o_READY = !o_VALID || i_READY. Combinational, with no path from i_ENABLE.
//   - Accept = i_ENABLE && o_READY. On accept, at the next edge:
//     - o_DATA_OUT <= i_DATA_IN - tap[DELAY-1] (wrap, no saturation, no flags)
//     - the delay line shifts: tap[0] <= i_DATA_IN, tap[k] <= tap[k-1]
//     - o_VALID <= 1
//     - o_PRIMED <= (count == DELAY), where count is the pre-increment value
//     - count <= min(count+1, DELAY), i.e. it saturates at DELAY
//   - Latency: one cycle from accept to o_VALID. Throughput: one sample per cycle.
//   - Consume without accept (o_VALID && i_READY, no i_ENABLE): o_VALID <= 0.
//     o_DATA_OUT and o_PRIMED hold their last values.
//   - Simultaneous consume and accept: the new result replaces the old one and o_VALID stays 1.
//   - Stall (o_VALID && !i_READY):
//     - o_READY=0, i_ENABLE is ignored and the sample is not consumed
//     - o_DATA_OUT, o_PRIMED and the delay line hold
//   - Unprimed history is zero, so the first output equals the first input.
//     This matches an accumulator whose total resets to 0.
//   - i_DATA_IN is don't-care when i_ENABLE=0. No state changes without an accept.
//
// STRUCTURE
//   - Shared package arith_pkg holds:
//     - default width constant ARITH_DATA_WIDTH=32
//     - typedef arith_word_t (logic [ARITH_DATA_WIDTH-1:0])
//     - the same constant is reused by accumulator
//   - One sub-module: delay_line (parameters WIDTH, DEPTH; ports i_CLK, i_RESET_N, i_SHIFT, i_DATA, o_TAP).
//     - it is a shift register with synchronous clear on reset
//     - o_TAP is the oldest entry
//   - Top level holds the subtractor, output register, prime counter and handshake logic.
//
// TESTING
//   1. Basic stream (DELAY=1, i_READY=1): inputs 5,7,12 on consecutive cycles.
//      -> o_DATA_OUT = 5,2,5, one cycle after each accept
//      -> o_PRIMED = 0,1,1
//   2. Wrap (DELAY=1): inputs 0x40000000 then 0xFFFFFFE0 -> second output 0xBFFFFFE0.
//      Inputs 1 then 0 -> 0xFFFFFFFF.
//   3. Backpressure: with o_VALID=1 holding 5, drop i_READY for 3 cycles and present 9.
//      -> o_READY=0 and o_DATA_OUT=5 is stable throughout
//      -> after i_READY=1, 9 is accepted and the next output is 9-5=4
//   4. Reset mid-stream: after inputs 3,4,8, hold i_RESET_N=0 for one cycle with i_ENABLE=1, then input 10.
//      -> o_VALID=0 after the reset edge
//      -> next output 10 with o_PRIMED=0
//   5. DELAY=3: inputs 1,2,3,4,5.
//      -> outputs 1,2,3,3,3
//      -> o_PRIMED = 0,0,0,1,1
//   6. Round trip: accumulator (DATA_WIDTH=32) feeding differentiator (DELAY=1).
//      Use 1000 random samples, random i_ENABLE gaps and random i_READY.
//      -> differentiator outputs equal the accumulator's accepted inputs, in order and bit-exact.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic word definitions for the accumulator / differentiator pair.
// Both blocks default to the same word width so they wrap identically.
package arith_pkg;
  localparam int ARITH_DATA_WIDTH = 32;
  typedef logic [ARITH_DATA_WIDTH-1:0] arith_word_t;
endpackage

// File: rtl/delay_line.sv
// Shift register of DEPTH words that advances only on i_SHIFT; o_TAP is the oldest entry.
// Latency DEPTH shifts; no backpressure of its own, the caller gates i_SHIFT.
module delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             i_SHIFT,
  input  logic [WIDTH-1:0] i_DATA,
  output logic [WIDTH-1:0] o_TAP
);

  logic [WIDTH-1:0] taps_q [DEPTH];

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
    end else if (i_SHIFT) begin
      taps_q[0] <= i_DATA;
      for (int k = 1; k < DEPTH; k++) taps_q[k] <= taps_q[k-1];
    end
  end

  assign o_TAP = taps_q[DEPTH-1];

endmodule

// File: rtl/differentiator.sv
// Streaming comb y[n] = x[n] - x[n-DELAY] (mod 2^DATA_WIDTH), one-cycle registered output.
// Accepts when the output slot is empty or being drained; stalls hold all state.
module differentiator
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = ARITH_DATA_WIDTH,
  parameter int DELAY      = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_N,
  input  logic                  i_ENABLE,
  input  logic [DATA_WIDTH-1:0] i_DATA_IN,
  output logic                  o_READY,
  output logic                  o_VALID,
  output logic [DATA_WIDTH-1:0] o_DATA_OUT,
  output logic                  o_PRIMED,
  input  logic                  i_READY
);

  if (DELAY < 1) begin : g_bad_delay
    $error("differentiator: DELAY must be >= 1");
  end

  localparam int CW = $clog2(DELAY + 1);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  primed_q, primed_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] tap;
  logic                  accept;

  assign o_READY = !valid_q || i_READY;
  assign accept  = i_ENABLE && o_READY;

  delay_line #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(DELAY)
  ) u_delay (
    .i_CLK    (i_CLK),
    .i_RESET_N(i_RESET_N),
    .i_SHIFT  (accept),
    .i_DATA   (i_DATA_IN),
    .o_TAP    (tap)
  );

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    primed_d = primed_q;
    count_d  = count_q;
    if (accept) begin
      data_d   = i_DATA_IN - tap;
      valid_d  = 1'b1;
      primed_d = (count_q == CW'(DELAY));
      // Count saturates so it only records whether the history is fully real.
      if (count_q != CW'(DELAY)) count_d = count_q + CW'(1);
    end else if (valid_q && i_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      primed_q <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      primed_q <= primed_d;
      count_q  <= count_d;
    end
  end

  assign o_VALID    = valid_q;
  assign o_DATA_OUT = data_q;
  assign o_PRIMED   = primed_q;

endmodule

// File: tb/tb_differentiator.sv
// Bench for differentiator: directed steps on DELAY=1 and DELAY=3 instances,
// then a random accumulator round trip plus a random DELAY=3 stream against a history model.
module tb_differentiator;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en1, rdy1, ordy1, vld1, prim1;
  arith_word_t din1, dout1;
  logic        en3, rdy3, ordy3, vld3, prim3;
  arith_word_t din3, dout3;

  differentiator #(.DATA_WIDTH(32), .DELAY(1)) u_d1 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en1), .i_DATA_IN(din1),
    .o_READY(ordy1), .o_VALID(vld1), .o_DATA_OUT(dout1), .o_PRIMED(prim1),
    .i_READY(rdy1)
  );

  differentiator #(.DATA_WIDTH(32), .DELAY(3)) u_d3 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en3), .i_DATA_IN(din3),
    .o_READY(ordy3), .o_VALID(vld3), .o_DATA_OUT(dout3), .o_PRIMED(prim3),
    .i_READY(rdy3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  arith_word_t q1[$], q3[$], hist3[$];
  logic        q1p[$], q3p[$];

  initial begin
    arith_word_t exp3_d [5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
    logic        exp3_p [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    arith_word_t tot, s, prev;
    int          acc_n, cyc;

    rst_n = 1'b0; en1 = 1'b0; din1 = '0; rdy1 = 1'b1;
    en3 = 1'b0; din3 = '0; rdy3 = 1'b1;
    step(); step();
    chk("rst_valid", 32'(vld1), 32'd0);
    chk("rst_data", dout1, 32'd0);
    chk("rst_primed", 32'(prim1), 32'd0);
    chk("rst_ready", 32'(ordy1), 32'd1);
    rst_n = 1'b1;

    // 1: basic stream 5,7,12
    en1 = 1'b1; din1 = 32'd5; step();
    chk("t1_v0", 32'(vld1), 32'd1); chk("t1_d0", dout1, 32'd5); chk("t1_p0", 32'(prim1), 32'd0);
    din1 = 32'd7; step();
    chk("t1_d1", dout1, 32'd2); chk("t1_p1", 32'(prim1), 32'd1);
    din1 = 32'd12; step();
    chk("t1_d2", dout1, 32'd5); chk("t1_p2", 32'(prim1), 32'd1);
    en1 = 1'b0; step();
    chk("t1_drain_v", 32'(vld1), 32'd0); chk("t1_hold_d", dout1, 32'd5);

    // 2: wrap-around
    en1 = 1'b1; din1 = 32'h4000_0000; step();
    din1 = 32'hFFFF_FFE0; step();
    chk("t2_wrap_a", dout1, 32'hBFFF_FFE0);
    din1 = 32'd1; step();
    din1 = 32'd0; step();
    chk("t2_wrap_b", dout1, 32'hFFFF_FFFF);
    en1 = 1'b0; step();

    // 3: backpressure, history is 0 so 5 comes out as 5
    en1 = 1'b1; din1 = 32'd5; step();
    chk("t3_first", dout1, 32'd5);
    rdy1 = 1'b0; din1 = 32'd9;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall_rdy", 32'(ordy1), 32'd0);
      step();
      chk("t3_stall_v", 32'(vld1), 32'd1);
      chk("t3_stall_d", dout1, 32'd5);
    end
    rdy1 = 1'b1;
    #1 chk("t3_release_rdy", 32'(ordy1), 32'd1);
    step();
    chk("t3_after", dout1, 32'd4);
    en1 = 1'b0; step();

    // 4: reset mid-stream with enable held high
    en1 = 1'b1; din1 = 32'd3; step();
    din1 = 32'd4; step();
    din1 = 32'd8; step();
    rst_n = 1'b0; din1 = 32'd99; step();
    chk("t4_rst_v", 32'(vld1), 32'd0);
    chk("t4_rst_p", 32'(prim1), 32'd0);
    rst_n = 1'b1; din1 = 32'd10; step();
    chk("t4_next_d", dout1, 32'd10);
    chk("t4_next_p", 32'(prim1), 32'd0);
    en1 = 1'b0; step();

    // 5: DELAY=3 comb, inputs 1..5
    en3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din3 = 32'(i + 1);
      step();
      chk("t5_d", dout3, exp3_d[i]);
      chk("t5_p", 32'(prim3), 32'(exp3_p[i]));
    end
    en3 = 1'b0; step();

    // 6: accumulator round trip on DELAY=1, random DELAY=3 stream alongside
    rst_n = 1'b0; step(); rst_n = 1'b1;
    tot = '0; acc_n = 0; cyc = 0;
    while ((acc_n < 1000 || q1.size() != 0 || q3.size() != 0) && cyc < 20000) begin
      cyc++;
      s = $urandom;
      if (acc_n < 1000) begin
        en1 = ($urandom_range(0, 3) != 0); rdy1 = ($urandom_range(0, 3) != 0);
        en3 = ($urandom_range(0, 2) != 0); rdy3 = ($urandom_range(0, 2) != 0);
      end else begin
        en1 = 1'b0; rdy1 = 1'b1; en3 = 1'b0; rdy3 = 1'b1;
      end
      din1 = tot + s;
      din3 = $urandom;
      #1;
      if (vld1 && rdy1) begin
        chk("rt_data", dout1, (q1.size() != 0) ? q1[0] : ~dout1);
        chk("rt_primed", 32'(prim1), (q1p.size() != 0) ? 32'(q1p[0]) : 32'(~prim1));
        if (q1.size() != 0) begin void'(q1.pop_front()); void'(q1p.pop_front()); end
      end
      if (en1 && ordy1) begin
        tot = din1;
        q1.push_back(s);
        q1p.push_back(acc_n > 0);
        acc_n++;
      end
      if (vld3 && rdy3) begin
        chk("r3_data", dout3, (q3.size() != 0) ? q3[0] : ~dout3);
        chk("r3_primed", 32'(prim3), (q3p.size() != 0) ? 32'(q3p[0]) : 32'(~prim3));
        if (q3.size() != 0) begin void'(q3.pop_front()); void'(q3p.pop_front()); end
      end
      if (en3 && ordy3) begin
        prev = (hist3.size() >= 3) ? hist3[hist3.size()-3] : '0;
        q3.push_back(din3 - prev);
        q3p.push_back(hist3.size() >= 3);
        hist3.push_back(din3);
      end
      step();
    end
    chk("rt_accepted", 32'(acc_n), 32'd1000);
    chk("rt_drained", 32'(q1.size()), 32'd0);
    chk("r3_drained", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
